// File: rtl/cta_wg_dispatcher.sv
// CTA workgroup dispatcher.
// Accepts workgroups from the host, parks each in the lowest free slot,
// issues one warp per cycle to the SM tagged {slot, warp index}, counts
// warp completions per slot and reports finished workgroups back to the
// host in slot order. Malformed requests and responses raise a sticky error.

`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif

module cta_wg_dispatcher #(
  parameter int WG_SLOT_DEPTH = 3,
  parameter int WF_CNT_WIDTH  = 5,
  parameter int WG_ID_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wg_req_valid_i,
  output logic                           wg_req_ready_o,
  input  logic [WF_CNT_WIDTH:0]          wg_req_num_wf_i,
  input  logic [WG_ID_WIDTH-1:0]         wg_req_id_i,
  output logic                           cta_req_valid_o,
  input  logic                           cta_req_ready_i,
  output logic [`TAG_WIDTH-1:0]          cta_req_wf_tag_o,
  input  logic                           cta_rsp_valid_i,
  output logic                           cta_rsp_ready_o,
  input  logic [`TAG_WIDTH-1:0]          cta_rsp_wf_tag_i,
  output logic                           wg_done_valid_o,
  input  logic                           wg_done_ready_i,
  output logic [WG_ID_WIDTH-1:0]         wg_done_id_o,
  output logic [(1<<WG_SLOT_DEPTH)-1:0]  slot_busy_o,
  output logic                           err_o
);

  localparam int NUM_SLOT = 1 << WG_SLOT_DEPTH;
  localparam int CNT_W    = WF_CNT_WIDTH + 1;
  localparam int TAG_W    = `TAG_WIDTH;
  localparam int LOW_W    = WF_CNT_WIDTH + WG_SLOT_DEPTH;
  localparam logic [CNT_W-1:0] MAX_WF = CNT_W'(1 << WF_CNT_WIDTH);

  typedef enum logic {
    IDLE,
    DISPATCH
  } state_t;

  state_t state_q, state_d;

  // Per-slot bookkeeping
  logic [NUM_SLOT-1:0]     in_use_q;
  logic [NUM_SLOT-1:0]     done_pending_q;
  logic [WG_ID_WIDTH-1:0]  wg_id_q [NUM_SLOT];
  logic [CNT_W-1:0]        cnt_q   [NUM_SLOT];

  // Workgroup currently being dispatched
  logic [WG_SLOT_DEPTH-1:0] cur_slot_q;
  logic [CNT_W-1:0]         cur_num_wf_q;
  logic [WF_CNT_WIDTH-1:0]  wf_idx_q;
  logic                     err_q;

  // Combinational helpers
  logic                     free_any;
  logic [WG_SLOT_DEPTH-1:0] free_slot;
  logic [WG_SLOT_DEPTH-1:0] done_slot;
  logic                     num_legal;
  logic                     wg_fire;
  logic                     alloc;
  logic                     cta_fire;
  logic                     last_wf;
  logic [WG_SLOT_DEPTH-1:0] rsp_slot;
  logic                     rsp_upper_nz;
  logic                     rsp_ok;
  logic                     rsp_bad;
  logic                     done_fire;

  // Priority encoders: lowest free slot and lowest slot awaiting host pickup.
  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    free_any  = 1'b0;
    free_slot = '0;
    done_slot = '0;
    for (int i = NUM_SLOT - 1; i >= 0; i--) begin
      if (!in_use_q[i]) begin
        free_any  = 1'b1;
        free_slot = WG_SLOT_DEPTH'(i);
      end
      if (done_pending_q[i]) begin
        done_slot = WG_SLOT_DEPTH'(i);
      end
    end
  end

  // Request legality and handshake qualifiers
  assign num_legal = (wg_req_num_wf_i != '0) && (wg_req_num_wf_i <= MAX_WF);
  assign wg_fire   = wg_req_valid_i && (state_q == IDLE) && free_any;
  assign alloc     = wg_fire && num_legal;
  assign cta_fire  = (state_q == DISPATCH) && cta_req_ready_i;
  assign last_wf   = ({1'b0, wf_idx_q} == (cur_num_wf_q - CNT_W'(1)));

  // Response decode: slot field, reserved upper bits, validity of the target
  assign rsp_slot     = cta_rsp_wf_tag_i[LOW_W-1:WF_CNT_WIDTH];
  assign rsp_upper_nz = |(cta_rsp_wf_tag_i >> LOW_W);
  assign rsp_ok       = cta_rsp_valid_i && in_use_q[rsp_slot] &&
                        (cnt_q[rsp_slot] != '0) && !rsp_upper_nz;
  assign rsp_bad      = cta_rsp_valid_i && !rsp_ok;

  assign done_fire = wg_done_valid_o && wg_done_ready_i;

  // FSM next-state and handshake outputs
  always_comb begin
    state_d         = state_q;
    wg_req_ready_o  = 1'b0;
    cta_req_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        wg_req_ready_o = free_any;
        if (alloc) begin
          state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        cta_req_valid_o = 1'b1;
        if (cta_fire && last_wf) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dispatch cursor: slot, warp count and running warp index of the active WG
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_slot_q   <= '0;
      cur_num_wf_q <= '0;
      wf_idx_q     <= '0;
    end else if (alloc) begin
      cur_slot_q   <= free_slot;
      cur_num_wf_q <= wg_req_num_wf_i;
      wf_idx_q     <= '0;
    end else if (cta_fire) begin
      wf_idx_q     <= wf_idx_q + WF_CNT_WIDTH'(1);
    end
  end

  // Slot table: allocation, completion counting and release. The three
  // events always touch distinct slots (free / counting / done), so they
  // can all land in one cycle without priority conflicts.
  // NOTE: the id and counter arrays are reset along with the flags so that
  // no stale workgroup can ever be reported after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_use_q       <= '0;
      done_pending_q <= '0;
      for (int i = 0; i < NUM_SLOT; i++) begin
        wg_id_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOT; i++) begin
        if (alloc && (free_slot == WG_SLOT_DEPTH'(i))) begin
          in_use_q[i] <= 1'b1;
          wg_id_q[i]  <= wg_req_id_i;
          cnt_q[i]    <= wg_req_num_wf_i;
        end
        if (rsp_ok && (rsp_slot == WG_SLOT_DEPTH'(i))) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
          if (cnt_q[i] == CNT_W'(1)) begin
            done_pending_q[i] <= 1'b1;
          end
        end
        if (done_fire && (done_slot == WG_SLOT_DEPTH'(i))) begin
          in_use_q[i]       <= 1'b0;
          done_pending_q[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky protocol error: illegal warp count or stray response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((wg_fire && !num_legal) || rsp_bad) begin
      err_q <= 1'b1;
    end
  end

  assign cta_req_wf_tag_o = TAG_W'({cur_slot_q, wf_idx_q});
  assign cta_rsp_ready_o  = 1'b1;
  assign wg_done_valid_o  = |done_pending_q;
  assign wg_done_id_o     = wg_id_q[done_slot];
  assign slot_busy_o      = in_use_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_cta_wg_dispatcher.sv
// Directed testbench for cta_wg_dispatcher with hand-computed expectations.

`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif

module tb_cta_wg_dispatcher;

  logic                  clk;
  logic                  rst_n;
  logic                  wg_req_valid_i;
  logic                  wg_req_ready_o;
  logic [5:0]            wg_req_num_wf_i;
  logic [15:0]           wg_req_id_i;
  logic                  cta_req_valid_o;
  logic                  cta_req_ready_i;
  logic [`TAG_WIDTH-1:0] cta_req_wf_tag_o;
  logic                  cta_rsp_valid_i;
  logic                  cta_rsp_ready_o;
  logic [`TAG_WIDTH-1:0] cta_rsp_wf_tag_i;
  logic                  wg_done_valid_o;
  logic                  wg_done_ready_i;
  logic [15:0]           wg_done_id_o;
  logic [7:0]            slot_busy_o;
  logic                  err_o;

  int n_vec = 0;
  int n_err = 0;

  cta_wg_dispatcher dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wg_req_valid_i   (wg_req_valid_i),
    .wg_req_ready_o   (wg_req_ready_o),
    .wg_req_num_wf_i  (wg_req_num_wf_i),
    .wg_req_id_i      (wg_req_id_i),
    .cta_req_valid_o  (cta_req_valid_o),
    .cta_req_ready_i  (cta_req_ready_i),
    .cta_req_wf_tag_o (cta_req_wf_tag_o),
    .cta_rsp_valid_i  (cta_rsp_valid_i),
    .cta_rsp_ready_o  (cta_rsp_ready_o),
    .cta_rsp_wf_tag_i (cta_rsp_wf_tag_i),
    .wg_done_valid_o  (wg_done_valid_o),
    .wg_done_ready_i  (wg_done_ready_i),
    .wg_done_id_o     (wg_done_id_o),
    .slot_busy_o      (slot_busy_o),
    .err_o            (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_wg(input logic [5:0] num, input logic [15:0] id);
    wg_req_valid_i  = 1'b1;
    wg_req_num_wf_i = num;
    wg_req_id_i     = id;
    check("wg_ready", 32'(wg_req_ready_o), 32'd1);
    tick();
    wg_req_valid_i  = 1'b0;
  endtask

  task automatic rsp(input logic [7:0] tag);
    cta_rsp_valid_i  = 1'b1;
    cta_rsp_wf_tag_i = tag;
    tick();
    cta_rsp_valid_i  = 1'b0;
  endtask

  task automatic take_done(input logic [15:0] id);
    check("done_valid", 32'(wg_done_valid_o), 32'd1);
    check("done_id", 32'(wg_done_id_o), 32'(id));
    wg_done_ready_i = 1'b1;
    tick();
    wg_done_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    wg_req_valid_i   = 1'b0;
    wg_req_num_wf_i  = '0;
    wg_req_id_i      = '0;
    cta_req_ready_i  = 1'b0;
    cta_rsp_valid_i  = 1'b0;
    cta_rsp_wf_tag_i = '0;
    wg_done_ready_i  = 1'b0;
    rst_n            = 1'b0;
    #1;
    check("rst_cta_valid", 32'(cta_req_valid_o), 32'd0);
    check("rst_done_valid", 32'(wg_done_valid_o), 32'd0);
    check("rst_busy", 32'(slot_busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    cta_req_ready_i = 1'b1;
  endtask

  initial begin
    logic [7:0] busy_exp;
    int         order [6] = '{0, 1, 3, 4, 5, 7};

    rst_n = 1'b0;
    #2;
    do_reset();
    check("rst_wg_ready", 32'(wg_req_ready_o), 32'd1);
    check("rsp_ready", 32'(cta_rsp_ready_o), 32'd1);

    // Basic three-warp workgroup
    send_wg(6'd3, 16'h0012);
    check("t1_valid0", 32'(cta_req_valid_o), 32'd1);
    check("t1_tag0", 32'(cta_req_wf_tag_o), 32'h00);
    check("t1_busy", 32'(slot_busy_o), 32'h01);
    tick();
    check("t1_tag1", 32'(cta_req_wf_tag_o), 32'h01);
    tick();
    check("t1_tag2", 32'(cta_req_wf_tag_o), 32'h02);
    tick();
    check("t1_idle", 32'(cta_req_valid_o), 32'd0);
    rsp(8'h00);
    rsp(8'h01);
    check("t1_not_done", 32'(wg_done_valid_o), 32'd0);
    rsp(8'h02);
    take_done(16'h0012);
    check("t1_done_clr", 32'(wg_done_valid_o), 32'd0);
    check("t1_busy_clr", 32'(slot_busy_o), 32'h00);

    // Backpressure mid-workgroup
    send_wg(6'd4, 16'h0034);
    check("t2_tag0", 32'(cta_req_wf_tag_o), 32'h00);
    tick();
    cta_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_valid", 32'(cta_req_valid_o), 32'd1);
      check("t2_hold_tag", 32'(cta_req_wf_tag_o), 32'h01);
      tick();
    end
    cta_req_ready_i = 1'b1;
    check("t2_tag1", 32'(cta_req_wf_tag_o), 32'h01);
    tick();
    check("t2_tag2", 32'(cta_req_wf_tag_o), 32'h02);
    tick();
    check("t2_tag3", 32'(cta_req_wf_tag_o), 32'h03);
    tick();
    check("t2_idle", 32'(cta_req_valid_o), 32'd0);
    for (int i = 0; i < 4; i++) rsp(8'(i));
    take_done(16'h0034);

    // Fill all eight slots with one-warp workgroups
    for (int i = 0; i < 8; i++) begin
      send_wg(6'd1, 16'(16'h0100 + i));
      check("t3_fill_tag", 32'(cta_req_wf_tag_o), 32'(i) << 5);
      tick();
    end
    check("t3_full_ready", 32'(wg_req_ready_o), 32'd0);
    check("t3_full_busy", 32'(slot_busy_o), 32'hFF);
    rsp(8'hA0);
    take_done(16'h0105);
    check("t3_busy_5free", 32'(slot_busy_o), 32'hDF);
    send_wg(6'd1, 16'h0200);
    check("t3_realloc_tag", 32'(cta_req_wf_tag_o), 32'hA0);
    tick();
    check("t3_busy_full", 32'(slot_busy_o), 32'hFF);

    // Two pending completions, host stalled: lowest slot shown first
    rsp(8'h40);
    rsp(8'hC0);
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_id", 32'(wg_done_id_o), 32'h0102);
      tick();
    end
    take_done(16'h0102);
    take_done(16'h0106);
    busy_exp = 8'hBB;
    check("t4_busy", 32'(slot_busy_o), 32'(busy_exp));
    for (int k = 0; k < 6; k++) begin
      rsp(8'(order[k] << 5));
      take_done((order[k] == 5) ? 16'h0200 : 16'(16'h0100 + order[k]));
    end
    check("t4_all_free", 32'(slot_busy_o), 32'h00);

    // Last response, new accept and done fire all in one cycle
    send_wg(6'd1, 16'h0050);
    tick();
    send_wg(6'd2, 16'h0051);
    tick();
    tick();
    rsp(8'h00);
    rsp(8'h20);
    check("t5_pre_id", 32'(wg_done_id_o), 32'h0050);
    check("t5_pre_busy", 32'(slot_busy_o), 32'h03);
    cta_rsp_valid_i  = 1'b1;
    cta_rsp_wf_tag_i = 8'h21;
    wg_done_ready_i  = 1'b1;
    send_wg(6'd1, 16'h0052);
    cta_rsp_valid_i  = 1'b0;
    wg_done_ready_i  = 1'b0;
    check("t5_busy", 32'(slot_busy_o), 32'h06);
    check("t5_done_valid", 32'(wg_done_valid_o), 32'd1);
    check("t5_done_id", 32'(wg_done_id_o), 32'h0051);
    check("t5_cta_valid", 32'(cta_req_valid_o), 32'd1);
    check("t5_cta_tag", 32'(cta_req_wf_tag_o), 32'h40);
    take_done(16'h0051);
    check("t5_dispatched", 32'(cta_req_valid_o), 32'd0);
    rsp(8'h40);
    take_done(16'h0052);
    check("t5_all_free", 32'(slot_busy_o), 32'h00);
    check("t5_err_clean", 32'(err_o), 32'd0);

    // Illegal warp count zero: accepted, not dispatched, error raised
    send_wg(6'd0, 16'h0077);
    check("t6_zero_cta", 32'(cta_req_valid_o), 32'd0);
    check("t6_zero_busy", 32'(slot_busy_o), 32'h00);
    check("t6_zero_err", 32'(err_o), 32'd1);
    do_reset();

    // Illegal warp count above maximum
    send_wg(6'd33, 16'h0078);
    check("t6_big_cta", 32'(cta_req_valid_o), 32'd0);
    check("t6_big_busy", 32'(slot_busy_o), 32'h00);
    check("t6_big_err", 32'(err_o), 32'd1);
    do_reset();

    // Maximum legal warp count dispatches
    send_wg(6'd32, 16'h0079);
    for (int i = 0; i < 32; i++) begin
      check("t6_max_tag", 32'(cta_req_wf_tag_o), 32'(i));
      tick();
    end
    check("t6_max_idle", 32'(cta_req_valid_o), 32'd0);
    check("t6_max_err", 32'(err_o), 32'd0);
    do_reset();

    // Stray response to an idle slot
    send_wg(6'd1, 16'h0011);
    tick();
    rsp(8'h60);
    check("t7_err", 32'(err_o), 32'd1);
    check("t7_no_done", 32'(wg_done_valid_o), 32'd0);
    tick();
    tick();
    check("t7_err_sticky", 32'(err_o), 32'd1);
    rsp(8'h00);
    take_done(16'h0011);
    do_reset();

    // Response to a slot whose counter already reached zero
    send_wg(6'd1, 16'h0013);
    tick();
    rsp(8'h00);
    check("t7b_err_before", 32'(err_o), 32'd0);
    rsp(8'h00);
    check("t7b_err_after", 32'(err_o), 32'd1);
    take_done(16'h0013);

    // Reset in the middle of dispatch abandons everything
    do_reset();
    send_wg(6'd1, 16'h0098);
    tick();
    rsp(8'h00);
    cta_req_ready_i = 1'b0;
    send_wg(6'd4, 16'h0099);
    check("t8_pre_valid", 32'(cta_req_valid_o), 32'd1);
    check("t8_pre_done", 32'(wg_done_valid_o), 32'd1);
    do_reset();
    tick();
    tick();
    check("t8_cta_valid", 32'(cta_req_valid_o), 32'd0);
    check("t8_done_valid", 32'(wg_done_valid_o), 32'd0);
    check("t8_busy", 32'(slot_busy_o), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
